// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Request/response bundle between the ICache fetch port, the
//             load/store buffer port, the memory-controller port and the
//             arbiter that serialises them.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    // Fetch port
    logic        ic_ask;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    // Load/store port
    logic        lsb_request;
    logic        lsb_lors;
    logic [5:0]  lsb_op;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic        lsb_valid;
    logic [31:0] lsb_val;
    // Memory-controller port
    logic        mc_request;
    logic        mc_src;
    logic        mc_lors;
    logic [5:0]  mc_op;
    logic [31:0] mc_addr;
    logic [31:0] mc_data;
    logic        mc_valid;
    logic [31:0] mc_val;
    // Status
    logic        busy;

    // Arbiter side
    modport slave (
        input  ic_ask, ic_addr,
        input  lsb_request, lsb_lors, lsb_op, lsb_addr, lsb_data,
        input  mc_valid, mc_val,
        output ic_valid, ic_inst,
        output lsb_valid, lsb_val,
        output mc_request, mc_src, mc_lors, mc_op, mc_addr, mc_data,
        output busy
    );

    // Requester / controller side
    modport master (
        output ic_ask, ic_addr,
        output lsb_request, lsb_lors, lsb_op, lsb_addr, lsb_data,
        output mc_valid, mc_val,
        input  ic_valid, ic_inst,
        input  lsb_valid, lsb_val,
        input  mc_request, mc_src, mc_lors, mc_op, mc_addr, mc_data,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester memory arbiter (ICache fetch vs. LSB) with one
//             outstanding transaction, anti-starvation counter for fetch and
//             flush-discard of in-flight fetches.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clr_in,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [1:0] c_STARVE_MAX = 2'd3;

    // Registered state and outputs
    state_t      r_state;
    logic [1:0]  r_starve;
    logic        r_discard;
    logic        r_mc_request;
    logic        r_mc_src;
    logic        r_mc_lors;
    logic [5:0]  r_mc_op;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_data;
    logic        r_ic_valid;
    logic [31:0] r_ic_inst;
    logic        r_lsb_valid;
    logic [31:0] r_lsb_val;

    // Next-state values
    state_t      w_state;
    logic [1:0]  w_starve;
    logic        w_discard;
    logic        w_mc_request;
    logic        w_mc_src;
    logic        w_mc_lors;
    logic [5:0]  w_mc_op;
    logic [31:0] w_mc_addr;
    logic [31:0] w_mc_data;
    logic        w_ic_valid;
    logic [31:0] w_ic_inst;
    logic        w_lsb_valid;
    logic [31:0] w_lsb_val;

    // Grant decision: fetch is blocked during a flush; LSB wins ties unless
    // the fetch side has already lost three times in a row.
    logic w_fetch_ok;
    logic w_grant_lsb;
    logic w_grant_fetch;
    logic w_flush_fetch;

    assign w_fetch_ok    = bus.ic_ask && !clr_in;
    assign w_grant_lsb   = bus.lsb_request && !(w_fetch_ok && (r_starve == c_STARVE_MAX));
    assign w_grant_fetch = w_fetch_ok && !w_grant_lsb;
    assign w_flush_fetch = clr_in && !r_mc_src;

    // Next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_starve     = r_starve;
        w_discard    = r_discard;
        w_mc_request = 1'b0;
        w_mc_src     = r_mc_src;
        w_mc_lors    = r_mc_lors;
        w_mc_op      = r_mc_op;
        w_mc_addr    = r_mc_addr;
        w_mc_data    = r_mc_data;
        w_ic_valid   = 1'b0;
        w_ic_inst    = r_ic_inst;
        w_lsb_valid  = 1'b0;
        w_lsb_val    = r_lsb_val;

        case (r_state)
            S_IDLE: begin
                w_discard = 1'b0;
                if (w_grant_lsb) begin
                    w_state      = S_ISSUE;
                    w_mc_request = 1'b1;
                    w_mc_src     = 1'b1;
                    w_mc_lors    = bus.lsb_lors;
                    w_mc_op      = bus.lsb_op;
                    w_mc_addr    = bus.lsb_addr;
                    w_mc_data    = bus.lsb_data;
                    // Count only grants that made a waiting fetch lose
                    if (bus.ic_ask) begin
                        w_starve = (r_starve == c_STARVE_MAX) ? c_STARVE_MAX
                                                               : r_starve + 2'd1;
                    end else begin
                        w_starve = 2'd0;
                    end
                end else if (w_grant_fetch) begin
                    w_state      = S_ISSUE;
                    w_mc_request = 1'b1;
                    w_mc_src     = 1'b0;
                    w_mc_lors    = 1'b0;
                    w_mc_op      = 6'd0;
                    w_mc_addr    = bus.ic_addr;
                    w_mc_data    = 32'd0;
                    w_starve     = 2'd0;
                end
            end
            S_ISSUE: begin
                w_state = S_WAIT;
                if (w_flush_fetch) begin
                    w_discard = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_flush_fetch) begin
                    w_discard = 1'b1;
                end
                if (bus.mc_valid) begin
                    w_state = S_RESP;
                    if (r_mc_src) begin
                        w_lsb_valid = 1'b1;
                        // Stores complete without touching the load result
                        if (!r_mc_lors) begin
                            w_lsb_val = bus.mc_val;
                        end
                    end else if (!w_discard) begin
                        w_ic_valid = 1'b1;
                        w_ic_inst  = bus.mc_val;
                    end
                end
            end
            S_RESP: begin
                w_state = S_GAP;
            end
            S_GAP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register; rdy_in low freezes everything
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_starve     <= 2'd0;
            r_discard    <= 1'b0;
            r_mc_request <= 1'b0;
            r_mc_src     <= 1'b0;
            r_mc_lors    <= 1'b0;
            r_mc_op      <= 6'd0;
            r_mc_addr    <= 32'd0;
            r_mc_data    <= 32'd0;
            r_ic_valid   <= 1'b0;
            r_ic_inst    <= 32'd0;
            r_lsb_valid  <= 1'b0;
            r_lsb_val    <= 32'd0;
        end else if (rdy_in) begin
            r_state      <= w_state;
            r_starve     <= w_starve;
            r_discard    <= w_discard;
            r_mc_request <= w_mc_request;
            r_mc_src     <= w_mc_src;
            r_mc_lors    <= w_mc_lors;
            r_mc_op      <= w_mc_op;
            r_mc_addr    <= w_mc_addr;
            r_mc_data    <= w_mc_data;
            r_ic_valid   <= w_ic_valid;
            r_ic_inst    <= w_ic_inst;
            r_lsb_valid  <= w_lsb_valid;
            r_lsb_val    <= w_lsb_val;
        end
    end

    assign bus.mc_request = r_mc_request;
    assign bus.mc_src     = r_mc_src;
    assign bus.mc_lors    = r_mc_lors;
    assign bus.mc_op      = r_mc_op;
    assign bus.mc_addr    = r_mc_addr;
    assign bus.mc_data    = r_mc_data;
    assign bus.ic_valid   = r_ic_valid;
    assign bus.ic_inst    = r_ic_inst;
    assign bus.lsb_valid  = r_lsb_valid;
    assign bus.lsb_val    = r_lsb_val;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus
//             randomized request traffic against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clr_in;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last delivered data and fetch-loss streak
    logic [31:0] m_ic_inst  = 32'd0;
    logic [31:0] m_lsb_val  = 32'd0;
    int          m_starve   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] a);
        bus.ic_ask  = 1'b1;
        bus.ic_addr = a;
    endtask

    task automatic set_lsb(input logic lors, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] d);
        bus.lsb_request = 1'b1;
        bus.lsb_lors    = lors;
        bus.lsb_op      = op;
        bus.lsb_addr    = a;
        bus.lsb_data    = d;
    endtask

    // One complete transaction starting from IDLE with requests already set.
    // delay = extra WAIT cycles before completion; stray = mc_valid during ISSUE.
    task automatic do_txn(input int delay, input bit stray, input logic [31:0] rval);
        bit          win_lsb;
        logic [31:0] e_addr, e_data;
        logic [5:0]  e_op;
        logic        e_lors;
        win_lsb = bus.lsb_request && !(bus.ic_ask && !clr_in && m_starve == 3);
        if (win_lsb) m_starve = bus.ic_ask ? ((m_starve == 3) ? 3 : m_starve + 1) : 0;
        else         m_starve = 0;
        e_addr = win_lsb ? bus.lsb_addr : bus.ic_addr;
        e_data = bus.lsb_data;
        e_op   = bus.lsb_op;
        e_lors = bus.lsb_lors;
        tick();                                   // ISSUE
        check("issue_req", bus.mc_request, 1);
        check("issue_src", bus.mc_src, win_lsb);
        check("issue_addr", bus.mc_addr, e_addr);
        check("issue_busy", bus.busy, 1);
        if (win_lsb) begin
            check("issue_lors", bus.mc_lors, e_lors);
            check("issue_op", bus.mc_op, e_op);
            check("issue_data", bus.mc_data, e_data);
        end
        if (stray) begin
            bus.mc_valid = 1'b1;
            bus.mc_val   = ~rval;
        end
        tick();                                   // WAIT
        bus.mc_valid = 1'b0;
        check("wait_req", bus.mc_request, 0);
        check("wait_novalid", bus.ic_valid | bus.lsb_valid, 0);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("wait_hold", bus.ic_valid | bus.lsb_valid | bus.mc_request, 0);
        end
        bus.mc_valid = 1'b1;
        bus.mc_val   = rval;
        tick();                                   // RESP
        bus.mc_valid = 1'b0;
        if (win_lsb) begin
            if (!e_lors) m_lsb_val = rval;
            check("resp_lsb_valid", bus.lsb_valid, 1);
            check("resp_ic_quiet", bus.ic_valid, 0);
            check("resp_lsb_val", bus.lsb_val, m_lsb_val);
            bus.lsb_request = 1'b0;
        end else begin
            m_ic_inst = rval;
            check("resp_ic_valid", bus.ic_valid, 1);
            check("resp_lsb_quiet", bus.lsb_valid, 0);
            check("resp_ic_inst", bus.ic_inst, m_ic_inst);
            bus.ic_ask = 1'b0;
        end
        tick();                                   // GAP
        check("gap_novalid", bus.ic_valid | bus.lsb_valid, 0);
        check("gap_addr_held", bus.mc_addr, e_addr);
        check("gap_busy", bus.busy, 1);
        tick();                                   // IDLE
        check("idle_busy", bus.busy, 0);
    endtask

    // Absolute time guard
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        bus.ic_ask = 1'b0; bus.ic_addr = 32'd0;
        bus.lsb_request = 1'b0; bus.lsb_lors = 1'b0; bus.lsb_op = 6'd0;
        bus.lsb_addr = 32'd0; bus.lsb_data = 32'd0;
        bus.mc_valid = 1'b0; bus.mc_val = 32'd0;
        tick(); tick();

        // Reset state
        check("rst_mc_request", bus.mc_request, 0);
        check("rst_mc_addr", bus.mc_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ic_inst", bus.ic_inst, 0);
        check("rst_lsb_val", bus.lsb_val, 0);
        rst_in = 1'b1;

        // Single fetch, completion five cycles after the request edge
        set_fetch(32'h0000_1000);
        do_txn(3, 0, 32'h00A0_0093);

        // Simultaneous requests: LSB first, then fetch
        set_fetch(32'h0000_2000);
        set_lsb(1'b0, 6'h03, 32'h0000_8000, 32'h0);
        do_txn(1, 0, 32'h1111_2222);
        check("simul_fetch_pending", bus.ic_ask, 1);
        do_txn(0, 0, 32'h3333_4444);

        // Starvation: three LSB wins, one fetch, then LSB again
        set_fetch(32'h0000_3000);
        for (int i = 0; i < 5; i++) begin
            if (!bus.lsb_request) set_lsb(1'b0, 6'h02, 32'h0000_9000 + 32'(i * 4), 32'h0);
            do_txn(i % 3, 0, 32'hA000_0000 + 32'(i));
        end

        // Fetch is never granted during a flush
        clr_in = 1'b1;
        set_fetch(32'h0000_4000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_block_req", bus.mc_request, 0);
            check("clr_block_busy", bus.busy, 0);
        end
        clr_in = 1'b0;

        // Flush during WAIT discards the fetch result
        m_starve = 0;
        tick();
        check("flush_issue_src", bus.mc_src, 0);
        check("flush_issue_req", bus.mc_request, 1);
        tick();
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        bus.mc_valid = 1'b1; bus.mc_val = 32'hDEAD_BEEF;
        tick();
        bus.mc_valid = 1'b0;
        bus.ic_ask = 1'b0;
        check("flush_no_ic_valid", bus.ic_valid, 0);
        check("flush_ic_inst_kept", bus.ic_inst, m_ic_inst);
        check("flush_resp_busy", bus.busy, 1);
        tick();
        check("flush_gap_novalid", bus.ic_valid, 0);
        tick();
        check("flush_idle", bus.busy, 0);
        set_lsb(1'b0, 6'h04, 32'h0000_A000, 32'h0);
        do_txn(1, 0, 32'h5555_6666);
        set_fetch(32'h0000_4004);
        do_txn(0, 0, 32'h7777_8888);

        // Store with rdy_in low during WAIT
        set_lsb(1'b1, 6'h0A, 32'h0000_B000, 32'hCAFE_F00D);
        m_starve = 0;
        tick();
        check("rdy_issue_src", bus.mc_src, 1);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_frozen_busy", bus.busy, 1);
            check("rdy_frozen_addr", bus.mc_addr, 32'h0000_B000);
            check("rdy_frozen_data", bus.mc_data, 32'hCAFE_F00D);
            check("rdy_frozen_valid", bus.lsb_valid | bus.mc_request, 0);
        end
        rdy_in = 1'b1;
        bus.mc_valid = 1'b1; bus.mc_val = 32'h0BAD_0BAD;
        tick();
        bus.mc_valid = 1'b0;
        bus.lsb_request = 1'b0;
        check("store_lsb_valid", bus.lsb_valid, 1);
        check("store_lsb_val_kept", bus.lsb_val, m_lsb_val);
        tick();
        check("store_single_pulse", bus.lsb_valid, 0);
        tick();
        check("store_idle", bus.busy, 0);

        // Asynchronous reset during WAIT
        set_lsb(1'b0, 6'h01, 32'h0000_C000, 32'h0);
        tick();
        tick();
        #3 rst_in = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_mc_addr", bus.mc_addr, 0);
        check("arst_mc_src", bus.mc_src, 0);
        check("arst_lsb_val", bus.lsb_val, 0);
        check("arst_ic_inst", bus.ic_inst, 0);
        bus.lsb_request = 1'b0;
        m_lsb_val = 32'd0; m_ic_inst = 32'd0; m_starve = 0;
        tick();
        rst_in = 1'b1;
        bus.mc_valid = 1'b1; bus.mc_val = 32'h1234_5678;
        tick();
        bus.mc_valid = 1'b0;
        tick();
        check("arst_stray_valid", bus.lsb_valid | bus.ic_valid, 0);
        check("arst_stray_busy", bus.busy, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!bus.ic_ask && $urandom_range(0, 1) == 1)
                set_fetch({$urandom_range(0, 32'hFFFF), 2'b00} & 32'hFFFF_FFFC);
            if (!bus.lsb_request && $urandom_range(0, 1) == 1)
                set_lsb(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, $urandom);
            if (!bus.ic_ask && !bus.lsb_request)
                set_lsb(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, $urandom);
            do_txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-003 rdy_in  input  1  global enable; low = hold every register, no outputs change.
REQ-004 clr_in  input  1  pipeline flush (branch mispredict); affects fetch path only.
REQ-005 ic_ask  input  1  ICache fetch request, level, held until ic_valid.
REQ-006 ic_addr  input  32  fetch byte address.
REQ-007 ic_valid  output  1  one-cycle pulse, ic_inst valid.
REQ-008 ic_inst  output  32  fetched word.
REQ-009 lsb_request  input  1  LSB request, level, held until lsb_valid.
REQ-010 lsb_lors  input  1  0 = load, 1 = store.
REQ-011 lsb_op  input  6  load/store opcode, passed through unmodified.
REQ-012 lsb_addr, lsb_data  input  32 each  address, store data.
REQ-013 lsb_valid  output  1  one-cycle pulse, access done.
REQ-014 lsb_val  output  32  load result; unchanged on store completion.
REQ-015 mc_request  output  1  one-cycle issue pulse to the memory controller.
REQ-016 mc_src  output  1  0 = fetch, 1 = LSB; drives the controller's select.
REQ-017 mc_lors, mc_op, mc_addr, mc_data  output  1/6/32/32  latched transaction fields, stable from issue until completion.
REQ-018 mc_valid  input  1  controller completion pulse.
REQ-019 mc_val  input  32  controller return data, valid with mc_valid.
REQ-020 busy  output  1  high in any state except IDLE.

Function
REQ-021 States: IDLE, ISSUE, WAIT, RESP, GAP; exactly one transaction is outstanding at any time.
REQ-022 IDLE, one request pending: grant that requester.
REQ-023 IDLE, both requests pending: grant LSB unless starve_cnt == 3, in which case grant fetch.
REQ-024 Fetch is never granted while clr_in is high.
REQ-025 On grant: latch the fields and mc_src; the next cycle is ISSUE with mc_request = 1 for exactly one cycle; then WAIT.
REQ-026 starve_cnt is 2 bits.
  - +1 (saturating at 3) on each LSB grant made while ic_ask is high.
  - Cleared on a fetch grant.
  - Cleared when ic_ask is low at grant time.
REQ-027 WAIT, mc_valid = 1: capture mc_val and go to RESP.
REQ-028 RESP lasts one cycle and pulses the granted requester's valid with the captured data.
REQ-029 After RESP: GAP for one cycle (requester deasserts its request), then IDLE.
REQ-030 Minimum turnaround, request at edge t with mc_valid at t+k: valid at t+k+1, next grant no earlier than t+k+3.
REQ-031 Flush in flight: clr_in high with a fetch in ISSUE or WAIT sets the discard flag.
  - On completion: no ic_valid pulse and ic_inst unchanged; RESP and GAP are still traversed.
  - The discard flag clears in IDLE.
REQ-032 clr_in never affects an LSB transaction or starve_cnt.
REQ-033 mc_valid outside WAIT is ignored.
REQ-034 A request dropped before grant is never issued.
REQ-035 All mc_* fields are held constant from grant until the cycle after RESP.

Reset
REQ-036 rst_in low, at any time including mid-transaction, forces:
  - State: IDLE, starve_cnt = 0, discard = 0.
  - Outputs: all zero.
  - The in-flight transaction is abandoned, with no valid pulse.
REQ-037 After rst_in rises: the first grant can occur on the first rdy_in-high edge.

Verification
REQ-038 Single fetch: ic_ask, addr 0x1000, controller returns 0x00A00093 after 5 cycles -> exactly one mc_request with mc_src = 0, mc_addr 0x1000; one ic_valid, ic_inst 0x00A00093.
REQ-039 Simultaneous: ic_ask and lsb_request in the same cycle -> LSB issued first; fetch issued after LSB's GAP; starve_cnt reaches 1, then clears to 0.
REQ-040 Starvation: lsb_request re-asserted after each completion, ic_ask held -> three LSB grants, then one fetch grant, then LSB again.
REQ-041 Flush: clr_in pulsed during WAIT of a fetch -> no ic_valid; next LSB request proceeds normally with lsb_val correct.
REQ-042 Store then rdy_in low for 3 cycles during WAIT with mc_valid held off -> all outputs frozen; completion resumes; lsb_valid single pulse; lsb_val unchanged.
REQ-043 Reset during WAIT -> all outputs 0 immediately (asynchronous); a later stray mc_valid produces no valid pulse.
